psum_collector: RTL and testbench
=================================

PSUM_COLLECTOR -- requirements
Module: psum_collector

Interface
REQ-001 The block SHALL have parameter col, default 8, meaning the number of array columns and therefore independent column queues.
REQ-002 The block SHALL have parameter psum_bw, default 16, meaning the width of one partial-sum word.
REQ-003 The block SHALL have parameter depth, default 8, meaning the entries per column queue; it is a power of two and at least 2.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  is the sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  is the asynchronous reset, active-low: asserted at 0.
REQ-007 in  input  psum_bw*col  carries the partial sums from the array's south edge; column c occupies bits [psum_bw*(c+1)-1 : psum_bw*c].
REQ-008 wr  input  col  carries per-column write strobes, driven by the array's per-column valid.
REQ-009 rd  input  1  is the read request that pops one word from every column at once.
REQ-010 out  output  psum_bw*col  is the registered read data, in the same column packing as in.
REQ-011 out_vld  output  1  pulses for one cycle when out holds newly popped data.
REQ-012 o_valid  output  1  is high when every column queue is non-empty.
REQ-013 o_full  output  1  is high when any column queue is full.
REQ-014 ovf  output  1  is the sticky overflow flag (see Configuration).

Function
REQ-015 Each column SHALL keep its own circular queue with a write pointer and a read pointer, each log2(depth)+1 bits wide; full and empty SHALL be decoded from the extra pointer bit.
REQ-016 When wr[c]=1 and column c is not full, the queue SHALL store in[c] at the write pointer and advance it; pointers wrap modulo 2*depth.
REQ-017 When wr[c]=1 and column c is full with no pop in the same cycle, the write SHALL be dropped and the pointer unchanged.
REQ-018 When column c is full and a pop and wr[c] occur in the same cycle, both SHALL take effect and the column SHALL stay full.
REQ-019 o_valid SHALL be combinational: the AND of all column non-empty flags. o_full SHALL be combinational: the OR of all column full flags.
REQ-020 A pop SHALL occur when rd=1 and o_valid=1, advancing every column read pointer by one.
REQ-021 On a pop, out SHALL load the head word of every column at the next rising edge (1-cycle latency), and out_vld SHALL be 1 for exactly that cycle.
REQ-022 When rd=1 and o_valid=0, the request SHALL be ignored: no pointers move, out holds, out_vld=0.
REQ-023 When no pop occurs, out SHALL hold its last value and out_vld SHALL be 0.
REQ-024 An empty column receiving a write in the same cycle as rd SHALL NOT pop, because o_valid is sampled before the write.
REQ-025 Back-to-back pops SHALL be supported at one per cycle while o_valid stays 1.

Reset
REQ-026 While reset=0, all pointers SHALL be cleared, and out=0, out_vld=0, o_valid=0, o_full=0 and ovf=0.
REQ-027 Reset asserted mid-operation SHALL discard all queued data immediately; queue storage contents need not be cleared.
REQ-028 Release of reset SHALL be used synchronously to clk.

Configuration
REQ-029 When macro PSUM_COLLECTOR_OVF_EN is defined, ovf SHALL set on any cycle in which a write is dropped per REQ-017, and SHALL stay set until reset.
REQ-030 When PSUM_COLLECTOR_OVF_EN is not defined, ovf SHALL be tied to 0 and no overflow logic SHALL be built; all other behaviour is identical.

Verification
REQ-031 Scenario, fill and drain: write column c with value 16'h0100+c for all columns, 3 cycles, then rd for 3 cycles -> o_valid=1 after the first write; out shows all three words in order, 1 cycle after each rd; o_valid=0 after the third pop.
REQ-032 Scenario, skewed columns: wr asserted diagonally (column c starts at cycle c), 2 words each -> o_valid rises only when column 7 gets its first word; rd before that leaves out unchanged and out_vld=0.
REQ-033 Scenario, full with concurrent pop: fill column 0 to 8 entries and all other columns to 1 entry, then assert wr[0] and rd together -> column 0 stays full, the new word is retained, and ovf stays 0.
REQ-034 Scenario, overflow: with column 3 full, assert wr[3] without rd -> the word is dropped; ovf=1 when PSUM_COLLECTOR_OVF_EN is defined, otherwise 0; later reads return the original 8 words.
REQ-035 Scenario, reset mid-stream: 5 words queued, pull reset low for 1 cycle -> o_valid=0, out=0, out_vld=0 at once; writes after reset release read back from the first entry.
REQ-036 Scenario, wrap-around: 20 writes and 20 pops interleaved per column with depth=8 -> data returns in order with no loss, and pointers wrap correctly.

Source files
------------

// File: rtl/psum_collector_if.sv
// psum_collector_if: partial-sum collector bus (array south edge in, popped rows out).
interface psum_collector_if #(
  parameter int col     = 8,
  parameter int psum_bw = 16
);
  logic [psum_bw*col-1:0] in;
  logic [psum_bw*col-1:0] out;
  logic [col-1:0]         wr;
  logic                   rd;
  logic                   out_vld;
  logic                   o_valid;
  logic                   o_full;
  logic                   ovf;
  modport master (output in, wr, rd, input out, out_vld, o_valid, o_full, ovf);
  modport slave  (input in, wr, rd, output out, out_vld, o_valid, o_full, ovf);
endinterface

// File: rtl/psum_collector.sv
// psum_collector: per-column circular queues popped in lockstep into a registered row.
// Optional sticky overflow flag built only when PSUM_COLLECTOR_OVF_EN is defined.
module psum_collector #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 8
) (
  input  logic             clk,
  input  logic             reset,
  psum_collector_if.slave  bus
);
  localparam int aw = $clog2(depth);
  localparam logic [aw:0] one = 1;
  logic [col-1:0]         w_empty;
  logic [col-1:0]         w_full;
  logic [col-1:0]         w_wen;
  logic [psum_bw*col-1:0] w_head;
  logic                   w_valid;
  logic                   w_pop;
  logic [psum_bw*col-1:0] r_out;
  logic                   r_out_vld;
  assign w_valid     = &(~w_empty);
  assign w_pop       = bus.rd && w_valid;
  assign bus.o_valid = w_valid;
  assign bus.o_full  = |w_full;
  assign bus.out     = r_out;
  assign bus.out_vld = r_out_vld;
  genvar c;
  generate
    for (c = 0; c < col; c++) begin : g_col
      logic [aw:0]        r_wp;
      logic [aw:0]        r_rp;
      logic [psum_bw-1:0] r_mem [depth];
      assign w_empty[c] = r_wp == r_rp;
      assign w_full[c]  = (r_wp[aw] != r_rp[aw]) && (r_wp[aw-1:0] == r_rp[aw-1:0]);
      // a pop frees the slot the write lands in, so full+pop still accepts
      assign w_wen[c]   = bus.wr[c] && (!w_full[c] || w_pop);
      assign w_head[c*psum_bw +: psum_bw] = r_mem[r_rp[aw-1:0]];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_wp <= '0;
          r_rp <= '0;
        end else begin
          if (w_wen[c]) r_wp <= r_wp + one;
          if (w_pop) r_rp <= r_rp + one;
        end
      end
      always_ff @(posedge clk) begin
        if (w_wen[c]) r_mem[r_wp[aw-1:0]] <= bus.in[c*psum_bw +: psum_bw];
      end
    end
  endgenerate
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out     <= '0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= w_pop;
      if (w_pop) r_out <= w_head;
    end
  end
`ifdef PSUM_COLLECTOR_OVF_EN
  logic r_ovf;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_ovf <= 1'b0;
    else if (|(bus.wr & w_full) && !w_pop) r_ovf <= 1'b1;
  end
  assign bus.ovf = r_ovf;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_psum_collector.sv
// tb_psum_collector: randomized + directed scoreboard bench against a queue-based model.
module tb_psum_collector;
  localparam int COL = 8, BW = 16, DEPTH = 8, W = COL * BW;
`ifdef PSUM_COLLECTOR_OVF_EN
  localparam bit OVF = 1'b1;
`else
  localparam bit OVF = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  psum_collector_if #(.col(COL), .psum_bw(BW)) bus ();
  psum_collector #(.col(COL), .psum_bw(BW), .depth(DEPTH)) dut (
    .clk(clk), .reset(reset), .bus(bus.slave));
  int tests = 0, fails = 0;
  logic [BW-1:0] mq [COL][$];
  logic [W-1:0]  eq [$];
  logic [W-1:0]  last_out = '0;
  logic          m_ovf = 1'b0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [W-1:0] pat(input int base);
    logic [W-1:0] d;
    for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'(base + c);
    return d;
  endfunction
  function automatic logic [W-1:0] rnd();
    logic [W-1:0] d;
    for (int c = 0; c < COL; c++) d[c*BW +: BW] = BW'($urandom);
    return d;
  endfunction
  // model: pop every column if all non-empty, then accept writes that fit
  task automatic step(input logic [COL-1:0] w, input logic r, input logic [W-1:0] d);
    logic v, f;
    logic [W-1:0] e;
    @(negedge clk);
    bus.wr = w; bus.rd = r; bus.in = d;
    #1;
    v = 1'b1; f = 1'b0;
    for (int c = 0; c < COL; c++) begin
      if (mq[c].size() == 0) v = 1'b0;
      if (mq[c].size() == DEPTH) f = 1'b1;
    end
    chk("o_valid", W'(bus.o_valid), W'(v));
    chk("o_full", W'(bus.o_full), W'(f));
    chk("ovf", W'(bus.ovf), W'(m_ovf));
    if (r && v) begin
      for (int c = 0; c < COL; c++) e[c*BW +: BW] = mq[c].pop_front();
      eq.push_back(e);
    end
    for (int c = 0; c < COL; c++)
      if (w[c]) begin
        if (mq[c].size() < DEPTH) mq[c].push_back(d[c*BW +: BW]);
        else if (OVF) m_ovf = 1'b1;
      end
  endtask
  task automatic do_reset();
    @(negedge clk);
    bus.wr = '0; bus.rd = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_o_valid", W'(bus.o_valid), '0);
    chk("rst_o_full", W'(bus.o_full), '0);
    chk("rst_out", bus.out, '0);
    chk("rst_out_vld", W'(bus.out_vld), '0);
    chk("rst_ovf", W'(bus.ovf), '0);
    for (int c = 0; c < COL; c++) mq[c].delete();
    eq.delete();
    last_out = '0;
    m_ovf = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
  endtask
  always @(negedge clk) begin
    if (reset) begin
      if (bus.out_vld) begin
        if (eq.size() == 0) begin
          tests++; fails++;
          $display("FAIL out_vld: got 1 expected 0 (no pop pending) at %0t", $time);
        end else begin
          last_out = eq.pop_front();
          chk("out", bus.out, last_out);
        end
      end else chk("out_hold", bus.out, last_out);
    end
  end
  initial begin
    logic [COL-1:0] w;
    bus.in = '0; bus.wr = '0; bus.rd = 1'b0;
    do_reset();
    for (int k = 0; k < 3; k++) step('1, 1'b0, pat(16'h0100 * (k + 1)));
    for (int k = 0; k < 4; k++) step('0, 1'b1, '0);
    for (int t = 0; t <= COL + 1; t++) begin
      w = '0;
      for (int c = 0; c < COL; c++) if (t >= c && t < c + 2) w[c] = 1'b1;
      step(w, 1'b1, pat(16'h0200 + 16 * t));
    end
    for (int k = 0; k < 3; k++) step('0, 1'b1, '0);
    do_reset();
    step('1, 1'b0, pat(16'h0300));
    for (int k = 1; k < DEPTH; k++) step(COL'(1), 1'b0, pat(16'h0310 + 16 * k));
    step(COL'(1), 1'b1, pat(16'h03f0));
    for (int k = 0; k < DEPTH; k++) step(~COL'(1), 1'b0, pat(16'h0400 + 16 * k));
    for (int k = 0; k < DEPTH + 2; k++) step('0, 1'b1, '0);
    do_reset();
    for (int k = 0; k < DEPTH; k++) step('1, 1'b0, pat(16'h0500 + 16 * k));
    step(COL'(8), 1'b0, pat(16'hdead));
    step('0, 1'b0, '0);
    for (int k = 0; k < DEPTH + 2; k++) step('0, 1'b1, '0);
    do_reset();
    for (int k = 0; k < 5; k++) step('1, 1'b0, pat(16'h0600 + 16 * k));
    step('0, 1'b1, '0);
    do_reset();
    for (int k = 0; k < 2; k++) step('1, 1'b0, pat(16'h0700 + 16 * k));
    for (int k = 0; k < 3; k++) step('0, 1'b1, '0);
    do_reset();
    for (int k = 0; k < 20; k++) begin
      step('1, 1'b0, rnd());
      step('0, 1'b1, '0);
    end
    for (int k = 0; k < 400; k++)
      step(COL'($urandom) | COL'($urandom), $urandom_range(0, 2) == 0, rnd());
    for (int k = 0; k < DEPTH + 3; k++) step('0, 1'b1, '0);
    step('0, 1'b0, '0);
    step('0, 1'b0, '0);
    chk("pending", W'(eq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
